// File: rtl/register_file_param_if.sv
// register_file_param_if
// ----------------------
// Bundle of the register file's bus signals: one write port, two read ports,
// the sequential-clear request/status pair and the write acknowledge.
//
// Parameters:
//   WIDTH  data width of each register (signed two's complement)
//   DEPTH  number of registers (>= 2); AW = $clog2(DEPTH) address bits
//
// Signals (direction seen from the register file, i.e. the slave modport):
//   write_enable    in   1       write request this cycle
//   write_reg_num   in   AW      write address
//   write_data      in   WIDTH   write value (signed)
//   read_reg_1_num  in   AW      read port 1 address
//   read_reg_2_num  in   AW      read port 2 address
//   read_data_1     out  WIDTH   read port 1 value (signed, combinational)
//   read_data_2     out  WIDTH   read port 2 value (signed, combinational)
//   clear_req       in   1       request a sequential clear of all registers
//   busy            out  1       high while the clear sequence runs
//   write_ack       out  1       registered pulse, cycle after an accepted write
//   state_dbg       out  1       clear FSM state (0 = IDLE, 1 = CLEAR)
//   clr_ptr_dbg     out  AW      clear pointer
//
// Handshake: a write is a single-cycle request with no ready/stall path.
// It is accepted at the rising edge when write_enable=1, busy=0, reset=0
// and write_reg_num < DEPTH; write_ack reports acceptance one cycle later.
// A write that is not accepted is simply dropped and never retried.
interface register_file_param_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic                    write_enable;
    logic [AW-1:0]           write_reg_num;
    logic signed [WIDTH-1:0] write_data;
    logic [AW-1:0]           read_reg_1_num;
    logic [AW-1:0]           read_reg_2_num;
    logic signed [WIDTH-1:0] read_data_1;
    logic signed [WIDTH-1:0] read_data_2;
    logic                    clear_req;
    logic                    busy;
    logic                    write_ack;
    logic                    state_dbg;
    logic [AW-1:0]           clr_ptr_dbg;

    // Requester side: drives requests and addresses, observes results.
    modport master (
        output write_enable,
        output write_reg_num,
        output write_data,
        output read_reg_1_num,
        output read_reg_2_num,
        output clear_req,
        input  read_data_1,
        input  read_data_2,
        input  busy,
        input  write_ack,
        input  state_dbg,
        input  clr_ptr_dbg
    );

    // Register file side.
    modport slave (
        input  write_enable,
        input  write_reg_num,
        input  write_data,
        input  read_reg_1_num,
        input  read_reg_2_num,
        input  clear_req,
        output read_data_1,
        output read_data_2,
        output busy,
        output write_ack,
        output state_dbg,
        output clr_ptr_dbg
    );
endinterface

// File: rtl/register_file_param.sv
// register_file_param
// -------------------
// Parameterised register file with two combinational read ports, one
// synchronous write port, a registered write acknowledge and a sequential
// clear engine that zeroes one register per clock.
//
// Ports:
//   clk    in  1   single clock, all state updates on the rising edge
//   reset  in  1   synchronous, active-high; clears all registers, returns
//                  the clear FSM to IDLE and aborts a clear in progress
//   bus    register_file_param_if.slave (see the interface file for the
//          individual signals)
//
// Parameters:
//   WIDTH  register width in bits (signed)
//   DEPTH  number of registers (>= 2); reads of addresses >= DEPTH return 0
//          and writes to them are dropped
//
// Configuration macro:
//   REGFILE_WRITE_BYPASS_EN  when defined, a read port addressing the
//          register being written by an accepted write returns write_data in
//          the same cycle; when undefined it returns the pre-write contents.
module register_file_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    register_file_param_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    // DEPTH always fits in AW+1 bits, so address range checks are done by
    // zero-extending the address by one bit and comparing unsigned.
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [AW-1:0]           clr_ptr;
    logic [AW-1:0]           clr_ptr_next;
    logic                    busy;

    logic signed [WIDTH-1:0] regs [DEPTH];

    logic                    write_in_range;
    logic                    write_accept;
    logic                    write_ack;
    logic                    read_1_in_range;
    logic                    read_2_in_range;
    logic signed [WIDTH-1:0] read_data_1;
    logic signed [WIDTH-1:0] read_data_2;

    // ------------------------------------------------------------------
    // Write acceptance
    // ------------------------------------------------------------------
    assign write_in_range = ({1'b0, bus.write_reg_num} < DEPTH_W);

    // reset is included so that the bypass path and the acknowledge agree
    // with the register array, where reset has priority over the write.
    assign write_accept = bus.write_enable && !busy && !reset && write_in_range;

    // ------------------------------------------------------------------
    // Clear FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Clear FSM: next-state logic
    // A clear request is only looked at in IDLE, so requests arriving
    // during CLEAR neither restart nor extend the sequence. The pointer is
    // parked at 0 in IDLE so every clear starts at register 0.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            IDLE: begin
                clr_ptr_next = '0;
                if (bus.clear_req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_ptr == LAST_IDX) begin
                    state_next   = IDLE;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_ptr_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Clear FSM: outputs (decoded from the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state == CLEAR);
    end

    // ------------------------------------------------------------------
    // Register array
    // While clearing, writes are already blocked by write_accept, so the
    // clear and write branches never compete for the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (busy) begin
            regs[clr_ptr] <= '0;
        end else if (write_accept) begin
            regs[bus.write_reg_num] <= bus.write_data;
        end
    end

    // ------------------------------------------------------------------
    // Write acknowledge: one cycle per accepted write, so back-to-back
    // writes produce a continuous high level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            write_ack <= 1'b0;
        end else begin
            write_ack <= write_accept;
        end
    end

    // ------------------------------------------------------------------
    // Read ports (combinational, independent)
    // ------------------------------------------------------------------
    assign read_1_in_range = ({1'b0, bus.read_reg_1_num} < DEPTH_W);
    assign read_2_in_range = ({1'b0, bus.read_reg_2_num} < DEPTH_W);

    always_comb begin
        read_data_1 = '0;
        if (read_1_in_range) begin
            read_data_1 = regs[bus.read_reg_1_num];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_accept && (bus.read_reg_1_num == bus.write_reg_num)) begin
            read_data_1 = bus.write_data;
        end
`endif
    end

    always_comb begin
        read_data_2 = '0;
        if (read_2_in_range) begin
            read_data_2 = regs[bus.read_reg_2_num];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_accept && (bus.read_reg_2_num == bus.write_reg_num)) begin
            read_data_2 = bus.write_data;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output hookup
    // ------------------------------------------------------------------
    assign bus.read_data_1 = read_data_1;
    assign bus.read_data_2 = read_data_2;
    assign bus.busy        = busy;
    assign bus.write_ack   = write_ack;
    assign bus.state_dbg   = state;
    assign bus.clr_ptr_dbg = clr_ptr;

endmodule
